seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered successor to the datapath ALU. Adds a 4-bit op code, shifts, unsigned compare, XOR/NOR, carry/overflow flags and an iterative unsigned multiply.
- Valid/ready handshakes on input and output let the multi-cycle multiply stall the execute stage cleanly.
- Sits in the execute stage between operand muxes and the result/flag latch.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  block accepts the operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- f  input  4  op code.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- y  output  WIDTH  result (low word for MULU).
- y_hi  output  WIDTH  high product word for MULU; 0 for all other ops.
- zero  output  1  result is zero (full 2*WIDTH product for MULU).
- carry  output  1  ADD carry-out; SUB no-borrow (a >= b unsigned); 0 for other ops.
- overflow  output  1  signed overflow for ADD/SUB; 0 for other ops.

Behaviour:
- Op codes 0xxx keep the legacy 3-bit meaning:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR
  - 0100 a&~b, 0101 a|~b, 0110 SUB, 0111 SLT (signed)
- Extended op codes:
  - 1000 SLL: a << b[SHW-1:0]
  - 1001 SRL, 1010 SRA
  - 1011 SLTU, 1100 MULU, 1101 NOR
  - 1110 and 1111 reserved: y=0, zero=1, no error
- All arithmetic is modulo 2^WIDTH. SLT/SLTU return 1 or 0, zero-extended.
- Accept condition: in_valid && in_ready.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- FSM states IDLE, MUL, DONE:
  - IDLE, accept a non-MULU op: register result and flags -> DONE. out_valid is high the cycle after accept (latency 1).
  - IDLE, accept MULU: load the multiplicand, the multiplier and a 2*WIDTH accumulator -> MUL, counter = 0.
  - MUL: one shift-add step per cycle. After WIDTH steps, write y/y_hi/zero -> DONE. out_valid rises exactly WIDTH+1 cycles after accept.
  - MUL: in_ready=0; in_valid is ignored.
  - DONE, out_ready=0: y, y_hi and all flags held stable; out_valid stays 1.
  - DONE, out_ready=1 with no accept -> IDLE; out_valid drops next cycle.
  - DONE, out_ready=1 with an accept: the new op is taken the same cycle. Single-cycle ops give one result per clock.
- Reset (reset_n=0, any time, including mid-MUL):
  - state=IDLE; out_valid, y, y_hi, carry, overflow = 0; zero = 1; counter = 0.
  - Any in-flight multiply is discarded.
- After reset_n release, in_ready=1 in the first cycle.
- Inputs a, b and f are sampled only at accept. Later changes do not affect an in-flight op.
- Shift amount uses only b[SHW-1:0]; upper bits are ignored.

Decomposition:
- Shared package alu_pkg holds:
  - alu_op_e, a 4-bit enum covering all codes above;
  - the state enum {IDLE, MUL, DONE};
  - a flags struct {zero, carry, overflow}.
- One natural sub-module, alu_comb: purely combinational single-cycle ops and flags, parametrised by WIDTH.
- seq_alu holds the FSM, handshakes, multiply datapath and output registers.

Test Plan:
- ADD a=0x7FFFFFFF, b=0x00000001 -> y=0x80000000, overflow=1, carry=0, zero=0; out_valid 1 cycle after accept.
- SUB a=b=0x00000005 -> y=0, zero=1, carry=1, overflow=0. Then ADD 0xFFFFFFFF+1 -> y=0, carry=1, zero=1.
- SLT a=0xFFFFFFFF, b=1 -> y=1; SLTU same operands -> y=0. SRA a=0x80000000, b=0x24 (shift 4) -> y=0xF8000000.
- MULU a=b=0xFFFFFFFF -> y_hi=0xFFFFFFFE, y=0x00000001, zero=0. out_valid exactly 33 cycles after accept; in_ready=0 throughout MUL.
- Backpressure: hold out_ready=0 for 3 cycles after an OR result -> y and flags stable, in_ready=0, pending input not taken. With out_ready=1 and 4 back-to-back ADDs -> 4 results on 4 consecutive cycles.
- Assert reset_n low at cycle 10 of MULU -> out_valid=0, zero=1, y=0. After release, in_ready=1 and ADD 2+3 -> y=5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states and the flag bundle.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'h0,
        OP_OR   = 4'h1,
        OP_ADD  = 4'h2,
        OP_XOR  = 4'h3,
        OP_ANDN = 4'h4,
        OP_ORN  = 4'h5,
        OP_SUB  = 4'h6,
        OP_SLT  = 4'h7,
        OP_SLL  = 4'h8,
        OP_SRL  = 4'h9,
        OP_SRA  = 4'hA,
        OP_SLTU = 4'hB,
        OP_MULU = 4'hC,
        OP_NOR  = 4'hD,
        OP_RSV0 = 4'hE,
        OP_RSV1 = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
    } alu_flags_t;

    localparam alu_flags_t FLAGS_RESET = '{zero: 1'b1, carry: 1'b0, overflow: 1'b0};

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU operations and flags; MULU and reserved codes yield zero here.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       f_i,
    output logic [WIDTH-1:0] y_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             overflow_o
);

    logic [WIDTH:0]          sum;
    logic [WIDTH:0]          diff;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [SHW-1:0]          sh;
    logic [WIDTH-1:0]        res;
    alu_op_e                 op;

    assign op   = alu_op_e'(f_i);
    assign a_s  = a_i;
    assign b_s  = b_i;
    assign sh   = b_i[SHW-1:0];
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        res        = '0;
        carry_o    = 1'b0;
        overflow_o = 1'b0;
        case (op)
            OP_AND:  res = a_i & b_i;
            OP_OR:   res = a_i | b_i;
            OP_ADD: begin
                res        = sum[WIDTH-1:0];
                carry_o    = sum[WIDTH];
                overflow_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_XOR:  res = a_i ^ b_i;
            OP_ANDN: res = a_i & ~b_i;
            OP_ORN:  res = a_i | ~b_i;
            OP_SUB: begin
                // Carry reports "no borrow", i.e. a >= b unsigned.
                res        = diff[WIDTH-1:0];
                carry_o    = ~diff[WIDTH];
                overflow_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            OP_SLL:  res = a_i << sh;
            OP_SRL:  res = a_i >> sh;
            OP_SRA:  res = a_s >>> sh;
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            OP_NOR:  res = ~(a_i | b_i);
            default: res = '0;
        endcase
    end

    assign y_o    = res;
    assign zero_o = (res == '0);

endmodule

// File: rtl/seq_alu.sv
// Registered execute-stage ALU with valid/ready handshakes and an iterative
// shift-add unsigned multiply that stalls the input side while it runs.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_hi,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    state_e             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [WIDTH-1:0]   y_hi_q, y_hi_d;
    alu_flags_t         flags_q, flags_d;

    logic [WIDTH-1:0]   comb_y;
    logic               comb_zero, comb_carry, comb_ovf;
    logic [2*WIDTH-1:0] step_acc;
    logic               accept;

    alu_comb #(.WIDTH(WIDTH), .SHW(SHW)) u_comb (
        .a_i        (a),
        .b_i        (b),
        .f_i        (f),
        .y_o        (comb_y),
        .zero_o     (comb_zero),
        .carry_o    (comb_carry),
        .overflow_o (comb_ovf)
    );

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        y_d      = y_q;
        y_hi_d   = y_hi_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    if (f == OP_MULU) begin
                        acc_d    = '0;
                        mcand_d  = {{WIDTH{1'b0}}, a};
                        mplier_d = b;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else begin
                        y_d     = comb_y;
                        y_hi_d  = '0;
                        flags_d = '{zero: comb_zero, carry: comb_carry, overflow: comb_ovf};
                        state_d = DONE;
                    end
                end else if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                // The final step's sum goes straight to the result registers.
                acc_d    = step_acc;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    y_d     = step_acc[WIDTH-1:0];
                    y_hi_d  = step_acc[2*WIDTH-1:WIDTH];
                    flags_d = '{zero: (step_acc == '0), carry: 1'b0, overflow: 1'b0};
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            y_q      <= '0;
            y_hi_q   <= '0;
            flags_q  <= FLAGS_RESET;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            y_q      <= y_d;
            y_hi_q   <= y_hi_d;
            flags_q  <= flags_d;
        end
    end

    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign y_hi      = y_hi_q;
    assign zero      = flags_q.zero;
    assign carry     = flags_q.carry;
    assign overflow  = flags_q.overflow;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=32).
module tb_seq_alu;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  f;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic [31:0] y_hi;
    logic        zero;
    logic        carry;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .f         (f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .y_hi      (y_hi),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed single-cycle vectors: op, a, b, expected y.
    logic [3:0]  cf [12] = '{4'h7, 4'hB, 4'hA, 4'h9, 4'h8, 4'h3,
                             4'hD, 4'h4, 4'h5, 4'h0, 4'hE, 4'hF};
    logic [31:0] ca [12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
                             32'h00000001, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFF00FF00,
                             32'h00000000, 32'h12345678, 32'h12345678, 32'hFFFFFFFF};
    logic [31:0] cb [12] = '{32'h00000001, 32'h00000001, 32'h00000024, 32'h00000024,
                             32'h00000021, 32'hFF00FF00, 32'h0F0F0F00, 32'hF0F0F0F0,
                             32'hFFFFFF00, 32'h0000FFFF, 32'h00000001, 32'hFFFFFFFF};
    logic [31:0] cy [12] = '{32'h00000001, 32'h00000000, 32'hF8000000, 32'h08000000,
                             32'h00000002, 32'h0FF00FF0, 32'h0000000F, 32'h0F000F00,
                             32'h000000FF, 32'h00005678, 32'h00000000, 32'h00000000};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = '0; b = '0; f = '0;
        repeat (3) step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (y !== 32'h0) begin errors++; $display("FAIL rst_y got %h want 0", y); end
        checks++; if (y_hi !== 32'h0) begin errors++; $display("FAIL rst_y_hi got %h want 0", y_hi); end
        checks++; if ({zero, carry, overflow} !== 3'b100) begin errors++; $display("FAIL rst_flags got %b want 100", {zero, carry, overflow}); end
        reset_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_add_overflow();
        drain();
        in_valid = 1'b1; f = 4'h2; a = 32'h7FFFFFFF; b = 32'h00000001;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency got %b want 1", out_valid); end
        checks++; if (y !== 32'h80000000) begin errors++; $display("FAIL add_y got %h want 80000000", y); end
        checks++; if ({zero, carry, overflow} !== 3'b001) begin errors++; $display("FAIL add_flags got %b want 001", {zero, carry, overflow}); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drop got %b want 0", out_valid); end
    endtask

    task automatic test_sub_zero();
        drain();
        in_valid = 1'b1; f = 4'h6; a = 32'h5; b = 32'h5;
        step();
        checks++; if (y !== 32'h0) begin errors++; $display("FAIL sub_y got %h want 0", y); end
        checks++; if ({zero, carry, overflow} !== 3'b110) begin errors++; $display("FAIL sub_flags got %b want 110", {zero, carry, overflow}); end
        f = 4'h2; a = 32'hFFFFFFFF; b = 32'h1;
        step();
        in_valid = 1'b0;
        checks++; if (y !== 32'h0) begin errors++; $display("FAIL addwrap_y got %h want 0", y); end
        checks++; if ({zero, carry, overflow} !== 3'b110) begin errors++; $display("FAIL addwrap_flags got %b want 110", {zero, carry, overflow}); end
        f = 4'h6; a = 32'h3; b = 32'h80000000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        checks++; if (y !== 32'h80000003) begin errors++; $display("FAIL subovf_y got %h want 80000003", y); end
        checks++; if ({zero, carry, overflow} !== 3'b001) begin errors++; $display("FAIL subovf_flags got %b want 001", {zero, carry, overflow}); end
    endtask

    task automatic test_logic_shift_cmp();
        drain();
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; f = cf[i]; a = ca[i]; b = cb[i];
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL op%0d_valid got %b want 1", i, out_valid); end
            checks++; if (y !== cy[i]) begin errors++; $display("FAIL op%0d_y f=%h got %h want %h", i, cf[i], y, cy[i]); end
            checks++; if (y_hi !== 32'h0) begin errors++; $display("FAIL op%0d_y_hi got %h want 0", i, y_hi); end
            checks++; if ({zero, carry, overflow} !== {(cy[i] == 32'h0), 2'b00}) begin
                errors++; $display("FAIL op%0d_flags got %b want %b", i, {zero, carry, overflow}, {(cy[i] == 32'h0), 2'b00});
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_mulu();
        drain();
        in_valid = 1'b1; f = 4'hC; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
        step();
        // Garbage on the inputs while the multiply runs must be ignored.
        f = 4'h2; a = 32'h1; b = 32'h1;
        for (int c = 1; c <= 32; c++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mul_in_ready c%0d got %b want 0", c, in_ready); end
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_early c%0d got %b want 0", c, out_valid); end
            if (c == 32) in_valid = 1'b0;
            step();
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mul_valid33 got %b want 1", out_valid); end
        checks++; if (y !== 32'h00000001) begin errors++; $display("FAIL mul_y got %h want 00000001", y); end
        checks++; if (y_hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL mul_y_hi got %h want FFFFFFFE", y_hi); end
        checks++; if ({zero, carry, overflow} !== 3'b000) begin errors++; $display("FAIL mul_flags got %b want 000", {zero, carry, overflow}); end
        drain();
        in_valid = 1'b1; f = 4'hC; a = 32'h0; b = 32'h12345678;
        step();
        in_valid = 1'b0;
        repeat (32) step();
        checks++; if ({out_valid, zero, y, y_hi} !== {2'b11, 64'h0}) begin
            errors++; $display("FAIL mul_zero got v=%b z=%b y=%h hi=%h want v=1 z=1 y=0 hi=0", out_valid, zero, y, y_hi);
        end
    endtask

    task automatic test_back_to_back();
        drain();
        out_ready = 1'b0;
        in_valid = 1'b1; f = 4'h1; a = 32'h0000000F; b = 32'h000000F0;
        step();
        f = 4'h2; a = 32'h1; b = 32'h1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d got %b want 0", c, in_ready); end
            checks++; if (out_valid !== 1'b1 || y !== 32'hFF || {zero, carry, overflow} !== 3'b000) begin
                errors++; $display("FAIL bp_hold c%0d got v=%b y=%h fl=%b want v=1 y=ff fl=000", c, out_valid, y, {zero, carry, overflow});
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || y !== 32'h2) begin errors++; $display("FAIL bp_pending got v=%b y=%h want v=1 y=2", out_valid, y); end
        for (int i = 0; i < 4; i++) begin
            a = 32'(i + 100); b = 32'd10;
            step();
            checks++; if (out_valid !== 1'b1 || y !== 32'(i + 110)) begin
                errors++; $display("FAIL b2b%0d got v=%b y=%h want v=1 y=%h", i, out_valid, y, 32'(i + 110));
            end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drop got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_mul();
        drain();
        in_valid = 1'b1; f = 4'hC; a = 32'h3; b = 32'h5;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || zero !== 1'b1 || y !== 32'h0 || y_hi !== 32'h0) begin
            errors++; $display("FAIL midmul_rst got v=%b z=%b y=%h hi=%h want v=0 z=1 y=0 hi=0", out_valid, zero, y, y_hi);
        end
        step();
        step();
        reset_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL midmul_release got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
        end
        in_valid = 1'b1; f = 4'h2; a = 32'h2; b = 32'h3;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || y !== 32'h5) begin errors++; $display("FAIL midmul_add got v=%b y=%h want v=1 y=5", out_valid, y); end
        repeat (40) step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midmul_ghost got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_zero();
        test_logic_shift_cmp();
        test_mulu();
        test_back_to_back();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
